// File: rtl/pellet_eater.sv
// Pellet-eating controller: after reset, counts every pellet in a 32x32 pellet map,
// then serves eat requests one tile at a time and keeps score.
module pellet_eater #(
  parameter int unsigned PELLET_POINTS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [4:0]  req_x,
  input  logic [4:0]  req_y,
  output logic        busy,
  output logic [4:0]  mem_x,
  output logic [4:0]  mem_y,
  output logic        mem_clear,
  input  logic        mem_rd,
  output logic        eaten,
  output logic [15:0] score,
  output logic [10:0] remaining,
  output logic        level_clear
);

  typedef enum logic [2:0] {SCAN, IDLE, LOOKUP, CHECK, CLEAR} state_t;

  state_t      state;
  logic [10:0] scan_cnt;
  logic [16:0] score_sum;

  // One spare bit catches the carry so the score clamps instead of wrapping.
  assign score_sum = {1'b0, score} + 17'(PELLET_POINTS);

  // NOTE: every register here is written with <= so all of them update together on
  // the edge; synchronous reset sits first so it overrides any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      scan_cnt    <= '0;
      busy        <= 1'b1;
      mem_x       <= '0;
      mem_y       <= '0;
      mem_clear   <= 1'b0;
      eaten       <= 1'b0;
      score       <= '0;
      remaining   <= '0;
      level_clear <= 1'b0;
    end else begin
      mem_clear   <= 1'b0;
      eaten       <= 1'b0;
      level_clear <= (state != SCAN) && (remaining == '0);
      case (state)
        SCAN: begin
          // Read data lags the address by one cycle, so cycle 0 has nothing to add.
          if (scan_cnt != '0) remaining <= remaining + {10'b0, mem_rd};
          if (scan_cnt == 11'd1024) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            scan_cnt       <= scan_cnt + 11'd1;
            {mem_y, mem_x} <= scan_cnt[9:0] + 10'd1;
          end
        end
        IDLE: begin
          if (req) begin
            {mem_y, mem_x} <= {req_y, req_x};
            state          <= LOOKUP;
            busy           <= 1'b1;
          end
        end
        LOOKUP: state <= CHECK;
        CHECK: begin
          if (mem_rd) begin
            state     <= CLEAR;
            mem_clear <= 1'b1;
            eaten     <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CLEAR: begin
          score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
          if (remaining != '0) remaining <= remaining - 11'd1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pellet_eater.sv
// Directed bench for pellet_eater: two instances (default points and 40000 points),
// each backed by a small registered-read pellet map that restores on reset.
module tb_pellet_eater;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        reset_a, req_a, busy_a, mem_clear_a, mem_rd_a, eaten_a, level_clear_a;
  logic [4:0]  req_x_a, req_y_a, mem_x_a, mem_y_a;
  logic [15:0] score_a;
  logic [10:0] remaining_a;
  logic [1023:0] init_a, map_a;

  logic        reset_b, req_b, busy_b, mem_clear_b, mem_rd_b, eaten_b, level_clear_b;
  logic [4:0]  req_x_b, req_y_b, mem_x_b, mem_y_b;
  logic [15:0] score_b;
  logic [10:0] remaining_b;
  logic [1023:0] init_b, map_b;

  pellet_eater dut_a (
    .clk(clk), .reset(reset_a), .req(req_a), .req_x(req_x_a), .req_y(req_y_a),
    .busy(busy_a), .mem_x(mem_x_a), .mem_y(mem_y_a), .mem_clear(mem_clear_a),
    .mem_rd(mem_rd_a), .eaten(eaten_a), .score(score_a), .remaining(remaining_a),
    .level_clear(level_clear_a)
  );

  pellet_eater #(.PELLET_POINTS(40000)) dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .req_x(req_x_b), .req_y(req_y_b),
    .busy(busy_b), .mem_x(mem_x_b), .mem_y(mem_y_b), .mem_clear(mem_clear_b),
    .mem_rd(mem_rd_b), .eaten(eaten_b), .score(score_b), .remaining(remaining_b),
    .level_clear(level_clear_b)
  );

  // Pellet maps: index {y,x}; restored from init on reset, registered read data.
  always @(posedge clk) begin
    if (reset_a) begin
      map_a <= init_a; mem_rd_a <= 1'b0;
    end else if (mem_clear_a) begin
      map_a[{mem_y_a, mem_x_a}] <= 1'b0; mem_rd_a <= 1'b0;
    end else begin
      mem_rd_a <= map_a[{mem_y_a, mem_x_a}];
    end
  end

  always @(posedge clk) begin
    if (reset_b) begin
      map_b <= init_b; mem_rd_b <= 1'b0;
    end else if (mem_clear_b) begin
      map_b[{mem_y_b, mem_x_b}] <= 1'b0; mem_rd_b <= 1'b0;
    end else begin
      mem_rd_b <= map_b[{mem_y_b, mem_x_b}];
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at a negedge inside a reset cycle; counts cycles until busy drops.
  task automatic release_and_scan_a(output int n);
    n = 0;
    reset_a = 1'b0;
    while (busy_a && n < 2000) begin
      step();
      n++;
    end
  endtask

  // Presents a one-cycle request; returns at the negedge of cycle E+1.
  task automatic pulse_req_a(input logic [4:0] x, input logic [4:0] y);
    req_a = 1'b1; req_x_a = x; req_y_a = y;
    step();
    req_a = 1'b0;
  endtask

  task automatic pulse_req_b(input logic [4:0] x, input logic [4:0] y);
    req_b = 1'b1; req_x_b = x; req_y_b = y;
    step();
    req_b = 1'b0;
  endtask

  initial begin
    int n;
    int eat_cnt;
    reset_a = 1'b1; req_a = 1'b0; req_x_a = '0; req_y_a = '0; init_a = '0;
    reset_b = 1'b1; req_b = 1'b0; req_x_b = '0; req_y_b = '0; init_b = '0;

    // Reset state, empty map
    step(); step();
    check("rst_busy", busy_a, 1);
    check("rst_mem_x", mem_x_a, 0);
    check("rst_mem_y", mem_y_a, 0);
    check("rst_mem_clear", mem_clear_a, 0);
    check("rst_eaten", eaten_a, 0);
    check("rst_score", score_a, 0);
    check("rst_remaining", remaining_a, 0);
    check("rst_level_clear", level_clear_a, 0);

    n = 0;
    reset_a = 1'b0;
    while (busy_a && n < 2000) begin
      step();
      n++;
      if (n == 37) begin
        check("scan37_mem_x", mem_x_a, 5);
        check("scan37_mem_y", mem_y_a, 1);
        check("scan37_mem_clear", mem_clear_a, 0);
      end
    end
    check("empty_scan_len", n, 1025);
    step(); step();
    check("empty_remaining", remaining_a, 0);
    check("empty_level_clear", level_clear_a, 1);
    check("empty_score", score_a, 0);

    // One pellet at (3,2)
    init_a = '0; init_a[67] = 1'b1;
    reset_a = 1'b1; step();
    release_and_scan_a(n);
    check("one_scan_len", n, 1025);
    check("one_remaining", remaining_a, 1);
    check("one_level_clear", level_clear_a, 0);
    step();
    pulse_req_a(5'd3, 5'd2);
    check("eat_busy_e1", busy_a, 1);
    step(); step();
    check("eat_mem_clear_e3", mem_clear_a, 1);
    check("eat_mem_x_e3", mem_x_a, 3);
    check("eat_mem_y_e3", mem_y_a, 2);
    check("eat_eaten_e3", eaten_a, 1);
    check("eat_level_clear_e3", level_clear_a, 0);
    step();
    check("eat_busy_e4", busy_a, 0);
    check("eat_eaten_e4", eaten_a, 0);
    check("eat_score_e4", score_a, 10);
    check("eat_remaining_e4", remaining_a, 0);
    step();
    check("eat_level_clear_e5", level_clear_a, 1);

    // Repeat request on an eaten tile
    pulse_req_a(5'd3, 5'd2);
    step(); step();
    check("miss_mem_clear_e3", mem_clear_a, 0);
    check("miss_eaten_e3", eaten_a, 0);
    check("miss_busy_e3", busy_a, 0);
    step();
    check("miss_score", score_a, 10);
    check("miss_level_clear", level_clear_a, 1);

    // Two pellets, req held high through scan and lookups
    init_a = '0; init_a[67] = 1'b1; init_a[295] = 1'b1;
    reset_a = 1'b1; req_a = 1'b1; req_x_a = 5'd7; req_y_a = 5'd9;
    step();
    release_and_scan_a(n);
    check("held_scan_len", n, 1025);
    check("held_remaining_pre", remaining_a, 2);
    check("held_score_pre", score_a, 0);
    eat_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (eaten_a === 1'b1) eat_cnt++;
    end
    req_a = 1'b0;
    repeat (5) step();
    check("held_eat_count", eat_cnt, 1);
    check("held_remaining", remaining_a, 1);
    check("held_score", score_a, 10);
    pulse_req_a(5'd3, 5'd2);
    repeat (3) step();
    check("second_score", score_a, 20);
    check("second_remaining", remaining_a, 0);

    // Reset at scan address 500
    reset_a = 1'b1; step();
    reset_a = 1'b0;
    repeat (500) step();
    check("mid_mem_x", mem_x_a, 20);
    check("mid_mem_y", mem_y_a, 15);
    check("mid_remaining", remaining_a, 2);
    reset_a = 1'b1; step();
    check("mid_rst_busy", busy_a, 1);
    check("mid_rst_mem_x", mem_x_a, 0);
    check("mid_rst_mem_y", mem_y_a, 0);
    check("mid_rst_remaining", remaining_a, 0);
    check("mid_rst_score", score_a, 0);
    release_and_scan_a(n);
    check("mid_rescan_len", n, 1025);
    check("mid_rescan_remaining", remaining_a, 2);

    // Reset while a hit is in CHECK
    pulse_req_a(5'd3, 5'd2);
    step();
    reset_a = 1'b1; step();
    check("abort_mem_clear", mem_clear_a, 0);
    check("abort_eaten", eaten_a, 0);
    check("abort_score", score_a, 0);
    release_and_scan_a(n);
    check("abort_rescan_len", n, 1025);
    check("abort_remaining", remaining_a, 2);

    // 40000 points per pellet, score saturates
    init_b = '0; init_b[0] = 1'b1; init_b[1023] = 1'b1;
    reset_b = 1'b1; step();
    n = 0;
    reset_b = 1'b0;
    while (busy_b && n < 2000) begin
      step();
      n++;
    end
    check("sat_scan_len", n, 1025);
    check("sat_remaining", remaining_b, 2);
    pulse_req_b(5'd0, 5'd0);
    repeat (3) step();
    check("sat_score_1", score_b, 40000);
    check("sat_remaining_1", remaining_b, 1);
    pulse_req_b(5'd31, 5'd31);
    repeat (3) step();
    check("sat_score_2", score_b, 65535);
    check("sat_remaining_2", remaining_b, 0);
    step();
    check("sat_level_clear", level_clear_b, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pellet_eater.md
PELLET_EATER -- requirements
Module: pellet_eater

Interface
REQ-001 SHALL have parameter PELLET_POINTS, default 10, points added to score per pellet eaten.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req  in  1  eat request for tile (req_x, req_y); sampled only while busy=0.
REQ-005 SHALL have port req_x  in  5  request tile column.
REQ-006 SHALL have port req_y  in  5  request tile row.
REQ-007 SHALL have port busy  out  1  high while scanning or processing a request.
REQ-008 SHALL have port mem_x  out  5  pellet-map port-B column address.
REQ-009 SHALL have port mem_y  out  5  pellet-map port-B row address.
REQ-010 SHALL have port mem_clear  out  1  pellet-map port-B clear strobe.
REQ-011 SHALL have port mem_rd  in  1  pellet-map port-B registered read data; valid one cycle after the address is presented with mem_clear=0.
REQ-012 SHALL have port eaten  out  1  one-cycle pulse per pellet removed.
REQ-013 SHALL have port score  out  16  accumulated score.
REQ-014 SHALL have port remaining  out  11  pellets left in the map (0..1024).
REQ-015 SHALL have port level_clear  out  1  high when remaining=0 after the scan completes.

Function
REQ-016 SHALL implement states SCAN, IDLE, LOOKUP, CHECK, CLEAR.
REQ-017 SHALL drive mem_x, mem_y, mem_clear, busy and eaten from registered state only; there SHALL be no combinational path from req/req_x/req_y to any output.
REQ-018 SCAN: SHALL sweep a 10-bit counter 0..1023 over consecutive cycles with mem_y=counter[9:5], mem_x=counter[4:0], and mem_clear=0.
REQ-019 SCAN: SHALL add mem_rd to remaining on the cycle after each address, for all 1024 addresses.
REQ-020 SCAN SHALL last exactly 1025 cycles after reset deasserts (1024 addresses plus one drain cycle), then enter IDLE.
REQ-021 busy SHALL be 1 in SCAN, LOOKUP, CHECK and CLEAR, and 0 in IDLE.
REQ-022 IDLE: on req=1, SHALL latch req_x/req_y and go to LOOKUP; while busy=1, req SHALL be ignored (no queueing; the requester retries).
REQ-023 LOOKUP (1 cycle): SHALL present the latched address with mem_clear=0, then go to CHECK.
REQ-024 CHECK (1 cycle): mem_rd=1 SHALL go to CLEAR; mem_rd=0 SHALL go to IDLE with no side effects.
REQ-025 CLEAR (1 cycle): SHALL present the latched address with mem_clear=1 and eaten=1; at the end of the cycle, score += PELLET_POINTS (saturating at 65535) and remaining -= 1 (saturating at 0); then go to IDLE.
REQ-026 Request latency: req accepted at edge E; eaten is high in cycle E+3; score/remaining are updated and busy is 0 from cycle E+4.
REQ-027 level_clear SHALL be high iff the state is not SCAN and remaining=0; it SHALL update the cycle after remaining reaches 0.
REQ-028 Requests SHALL still be serviced when level_clear=1 (all reads return 0, so no effect).
REQ-029 score arithmetic SHALL be 17-bit internally and clamp to 16'hFFFF; the score SHALL never wrap.

Reset
REQ-030 While reset=1: state SHALL be SCAN with counter=0; busy=1, mem_x=0, mem_y=0, mem_clear=0, eaten=0, score=0, remaining=0, level_clear=0.
REQ-031 The pellet map SHALL share this reset, so the scan after reset SHALL count the restored map.
REQ-032 Reset asserted mid-scan or mid-request SHALL abort immediately, with no clear strobe or score update issued in the reset cycle, and SHALL restart the scan from address 0.

Verification
REQ-033 All-zero model map, release reset -> busy high for 1025 cycles; then remaining=0, level_clear=1, score=0.
REQ-034 Map with one pellet at (x=3,y=2), req (3,2) after scan -> mem_clear=1 at mem_x=3/mem_y=2 in cycle E+3, eaten pulse, score=10, remaining 1->0, level_clear=1.
REQ-035 Repeat req (3,2) -> no mem_clear, no eaten, score stays 10, busy low at E+3.
REQ-036 req held high during scan and during LOOKUP -> only requests sampled in IDLE are processed; remaining and score change exactly once per pellet.
REQ-037 PELLET_POINTS=40000 with two pellets, eat both -> score 40000 then 65535 (saturated).
REQ-038 Reset at scan address 500, then release -> counter restarts at 0, remaining cleared, full 1025-cycle scan repeats with the correct count.
